// File: rtl/spi_flash_if.sv
// SPI pins plus the word-wide backing-memory read port of the simulated boot flash.
interface spi_flash_if #(
  parameter int DATA_W = 32
);
  logic              sck;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic              rd_req;
  logic [31:0]       rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              cmd_err;

  modport slave (
    input  sck, ss, mosi, rd_ack, rd_data,
    output miso, rd_req, rd_addr, cmd_err
  );

  modport master (
    output sck, ss, mosi, rd_ack, rd_data,
    input  miso, rd_req, rd_addr, cmd_err
  );
endinterface

// File: rtl/spi_flash_slave.sv
// SPI NOR-flash slave (03h/0Bh/05h/9Fh), oversampled on clk, reads served from a word port.
// state | meaning
// IDLE  | deselected, waiting for ss low
// CMD   | shifting in the 8-bit opcode
// ADDR  | shifting in 8*ADDR_BYTES address bits
// DUMMY | fast-read dummy clocks
// DATA  | streaming memory bytes, prefetching the next word
// STAT  | repeating STATUS byte
// ID    | repeating the 3 JEDEC_ID bytes
// ERR   | unsupported opcode, ignore until ss high
module spi_flash_slave #(
  parameter int          ADDR_BYTES = 3,
  parameter int          DUMMY_CYC  = 8,
  parameter int          DATA_W     = 32,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
  parameter logic [7:0]  STATUS     = 8'h00
) (
  input logic        clk,
  input logic        rst_n,
  spi_flash_if.slave bus
);
  localparam int BPW = DATA_W / 8;
  localparam int LB = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [31:0] AMASK = (ADDR_BYTES == 4) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
  localparam logic [31:0] WMASK = ~(32'(BPW) - 32'd1);
  localparam logic [5:0] ABITS_M1 = 6'(8 * ADDR_BYTES - 1);
  localparam logic [5:0] DUMMY_M1 = (DUMMY_CYC > 0) ? 6'(DUMMY_CYC - 1) : 6'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_STAT, S_ID, S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        sck_q;
  logic [1:0]        ss_q, mosi_q;
  logic [30:0]       sh;
  logic [5:0]        cnt;
  logic [7:0]        cmd;
  logic [2:0]        bit_idx;
  logic [1:0]        id_byte;
  logic [LB-1:0]     byte_off;
  logic [DATA_W-1:0] cur_buf, nxt_buf;
  logic              cur_valid, nxt_valid, req_tgt_nxt, pf_pend;
  logic              swap, pf_fire, ack_ok, word_last;
  logic [4:0]        id_pos;

  wire        sck_rise  = sck_q[1] & ~sck_q[2];
  wire        sck_fall  = ~sck_q[1] & sck_q[2];
  wire        ss_off    = ss_q[1];
  wire [31:0] sh_in     = {sh, mosi_q[1]};
  wire        last_rise = sck_rise && (cnt == 6'd0);

  // ss synchroniser resets to "deselected" so the FSM does not wake before the pin is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      ss_q   <= 2'b11;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], bus.sck};
      ss_q   <= {ss_q[0], bus.ss};
      mosi_q <= {mosi_q[0], bus.mosi};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ss_off) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nx = S_CMD;
        S_CMD: if (last_rise) begin
          case (sh_in[7:0])
            8'h03, 8'h0B: state_nx = S_ADDR;
            8'h05:        state_nx = S_STAT;
            8'h9F:        state_nx = S_ID;
            default:      state_nx = S_ERR;
          endcase
        end
        S_ADDR:  if (last_rise) state_nx = (cmd == 8'h0B && DUMMY_CYC != 0) ? S_DUMMY : S_DATA;
        S_DUMMY: if (last_rise) state_nx = S_DATA;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    word_last = (byte_off == LB'(BPW - 1));
    swap      = (state == S_DATA) && sck_fall && (bit_idx == 3'd0) && word_last;
    pf_fire   = (state == S_DATA) && !sck_fall && pf_pend && !bus.rd_req;
    ack_ok    = bus.rd_req && bus.rd_ack && !ss_off;
    id_pos    = {2'd2 - id_byte, bit_idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.miso    <= 1'b1;
      bus.rd_req  <= 1'b0;
      bus.rd_addr <= '0;
      bus.cmd_err <= 1'b0;
      sh          <= '0;
      cnt         <= '0;
      cmd         <= '0;
      bit_idx     <= '0;
      id_byte     <= '0;
      byte_off    <= '0;
      cur_buf     <= '0;
      nxt_buf     <= '0;
      cur_valid   <= 1'b0;
      nxt_valid   <= 1'b0;
      req_tgt_nxt <= 1'b0;
      pf_pend     <= 1'b0;
    end else if (ss_off) begin
      bus.miso  <= 1'b1;
      bus.rd_req <= 1'b0;
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
      pf_pend   <= 1'b0;
      cnt       <= 6'd7;
    end else begin
      case (state)
        S_IDLE: cnt <= 6'd7;
        S_CMD: if (sck_rise) begin
          sh  <= sh_in[30:0];
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            cmd     <= sh_in[7:0];
            cnt     <= ABITS_M1;
            bit_idx <= 3'd7;
            id_byte <= 2'd0;
            if (state_nx == S_ERR) bus.cmd_err <= 1'b1;
          end
        end
        S_ADDR: if (sck_rise) begin
          sh  <= sh_in[30:0];
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            bus.rd_req  <= 1'b1;
            bus.rd_addr <= sh_in & AMASK & WMASK;
            req_tgt_nxt <= 1'b0;
            cur_valid   <= 1'b0;
            nxt_valid   <= 1'b0;
            pf_pend     <= 1'b0;
            byte_off    <= (BPW > 1) ? sh_in[LB-1:0] : '0;
            bit_idx     <= 3'd7;
            cnt         <= DUMMY_M1;
          end
        end
        S_DUMMY: if (sck_rise) cnt <= cnt - 6'd1;
        S_DATA: begin
          if (sck_fall) begin
            bus.miso <= cur_valid ? cur_buf[{byte_off, bit_idx}] : 1'b1;
            bit_idx  <= bit_idx - 3'd1;
            if (bit_idx == 3'd7 && word_last) pf_pend <= 1'b1;
            if (bit_idx == 3'd0) begin
              byte_off <= word_last ? '0 : byte_off + LB'(1);
              if (word_last) begin
                cur_buf     <= nxt_buf;
                cur_valid   <= nxt_valid;
                nxt_valid   <= 1'b0;
                req_tgt_nxt <= 1'b0;
              end
            end
          end
          // a prefetch issued after the swap has to land in the (now empty) current buffer
          if (pf_fire) begin
            bus.rd_req  <= 1'b1;
            bus.rd_addr <= (bus.rd_addr + 32'(BPW)) & AMASK;
            req_tgt_nxt <= cur_valid;
            pf_pend     <= 1'b0;
          end
        end
        S_STAT: if (sck_fall) begin
          bus.miso <= STATUS[bit_idx];
          bit_idx  <= bit_idx - 3'd1;
        end
        S_ID: if (sck_fall) begin
          bus.miso <= JEDEC_ID[id_pos];
          bit_idx  <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) id_byte <= (id_byte == 2'd2) ? 2'd0 : id_byte + 2'd1;
        end
        default: ;
      endcase
      if (ack_ok) begin
        bus.rd_req <= 1'b0;
        if (req_tgt_nxt && !swap) begin
          nxt_buf   <= bus.rd_data;
          nxt_valid <= 1'b1;
        end else begin
          cur_buf   <= bus.rd_data;
          cur_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave: SPI mode-0 master, word memory responder, byte-level model.
module tb_spi_flash_slave;
  localparam int H = 5;
  localparam logic [23:0] JID = 24'hEF4018;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_if #(.DATA_W(32)) bus();

  spi_flash_slave #(
    .ADDR_BYTES(3), .DUMMY_CYC(8), .DATA_W(32), .JEDEC_ID(JID), .STATUS(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [logic [31:0]];
  int req_addr_q[$];
  int req_byte_q[$];
  int bytes_done = 0;
  logic stall = 1'b0, late_ack = 1'b0;
  logic model_err = 1'b0, err_chk = 1'b0, idle_chk = 1'b0, noreq_chk = 1'b0;
  logic [7:0] rx[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    w = mem.exists(wa) ? mem[wa] : 32'h0;
    return 8'(w >> (8 * (a % 4)));
  endfunction

  function automatic logic [7:0] id_byte(input int i);
    return 8'(JID >> (8 * (2 - (i % 3))));
  endfunction

  // memory responder: acks one clock after seeing a request
  initial begin
    bus.rd_ack = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.rd_ack = 1'b0;
      if (late_ack) begin
        bus.rd_ack = 1'b1;
        bus.rd_data = 32'hDEAD_BEEF;
        late_ack = 1'b0;
      end else if (!stall && rst_n && bus.rd_req) begin
        bus.rd_ack = 1'b1;
        bus.rd_data = mem_byte(bus.rd_addr) | (32'(mem_byte(bus.rd_addr + 1)) << 8)
                    | (32'(mem_byte(bus.rd_addr + 2)) << 16) | (32'(mem_byte(bus.rd_addr + 3)) << 24);
        req_addr_q.push_back(int'(bus.rd_addr));
        req_byte_q.push_back(bytes_done);
      end
    end
  end

  // per-cycle compare against the model flags
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_chk) chk("cmd_err", bus.cmd_err, model_err);
        if (idle_chk) chk("miso_idle", bus.miso, 1'b1);
        if (noreq_chk) chk("no_rd_req", bus.rd_req, 1'b0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_x(input logic b, output logic r);
    bus.mosi = b;
    clk_wait(H);
    r = bus.miso;
    bus.sck = 1'b1;
    clk_wait(H);
    bus.sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] o, output logic [7:0] i);
    logic r;
    for (int k = 7; k >= 0; k--) begin
      bit_x(o[k], r);
      i[k] = r;
    end
  endtask

  task automatic frame_start();
    bus.ss = 1'b0;
    bytes_done = 0;
    rx.delete();
    clk_wait(4);
  endtask

  task automatic frame_end();
    idle_chk = 1'b0;
    clk_wait(2);
    bus.ss = 1'b1;
    clk_wait(6);
    idle_chk = 1'b1;
  endtask

  task automatic send_read(input logic [7:0] op, input logic [31:0] addr, input int n,
                           input string name);
    logic [7:0] d;
    frame_start();
    xfer(op, d);
    for (int b = 2; b >= 0; b--) xfer(8'(addr >> (8 * b)), d);
    if (op == 8'h0B) begin
      xfer(8'h00, d);
      chk({name, "_dummy"}, d, 8'hFF);
    end
    idle_chk = 1'b0;
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, d);
      rx.push_back(d);
      chk(name, d, mem_byte((addr + i) & 32'h00FF_FFFF));
      bytes_done++;
    end
    frame_end();
  endtask

  initial begin
    int base, cnt, n;
    logic [7:0] d;
    logic r;
    bus.ss = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
    mem[32'h0] = 32'hDDCC_BBAA;
    mem[32'h4] = 32'h4433_2211;
    mem[32'h8] = 32'h8877_6655;
    mem[32'hC] = 32'hC0B0_A090;

    clk_wait(3);
    chk("rst_miso", bus.miso, 1'b1);
    chk("rst_rd_req", bus.rd_req, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 32'h0);
    chk("rst_cmd_err", bus.cmd_err, 1'b0);
    rst_n = 1'b1;
    clk_wait(5);
    err_chk = 1'b1;
    idle_chk = 1'b1;

    // 1: aligned read of one word
    base = req_addr_q.size();
    send_read(8'h03, 32'h4, 4, "t1_byte");
    chk("t1_lit0", rx[0], 8'h11);
    chk("t1_lit3", rx[3], 8'h44);
    chk("t1_first_addr", req_addr_q[base], 32'h4);
    cnt = 0;
    for (int i = base; i < req_addr_q.size(); i++) if (req_byte_q[i] < 3) cnt++;
    chk("t1_req_count", cnt, 1);

    // 2: unaligned start crossing a word boundary
    base = req_addr_q.size();
    send_read(8'h03, 32'h6, 6, "t2_byte");
    chk("t2_lit0", rx[0], 8'h33);
    chk("t2_lit5", rx[5], 8'h88);
    chk("t2_first_addr", req_addr_q[base], 32'h4);
    chk("t2_pf_addr", req_addr_q[base + 1], 32'h8);
    chk("t2_pf_during_byte44", req_byte_q[base + 1], 1);

    // 3: fast read with dummy clocks
    send_read(8'h0B, 32'h0, 4, "t3_byte");
    chk("t3_lit0", rx[0], 8'hAA);
    chk("t3_lit3", rx[3], 8'hDD);

    // 4: JEDEC ID and status
    base = req_addr_q.size();
    frame_start();
    xfer(8'h9F, d);
    idle_chk = 1'b0;
    noreq_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, d);
      rx.push_back(d);
      chk("t4_id", d, id_byte(i));
    end
    frame_end();
    chk("t4_lit0", rx[0], 8'hEF);
    chk("t4_lit1", rx[1], 8'h40);
    chk("t4_lit3", rx[3], 8'hEF);
    frame_start();
    xfer(8'h05, d);
    idle_chk = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xfer(8'h00, d);
      chk("t4_status", d, 8'h00);
    end
    frame_end();
    noreq_chk = 1'b0;
    chk("t4_no_fetch", req_addr_q.size(), base);

    // 5: unsupported opcode sets sticky error
    frame_start();
    noreq_chk = 1'b1;
    err_chk = 1'b0;
    xfer(8'h02, d);
    clk_wait(5);
    model_err = 1'b1;
    err_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer(8'h00, d);
      chk("t5_err_miso", d, 8'hFF);
    end
    frame_end();
    noreq_chk = 1'b0;
    send_read(8'h03, 32'h4, 2, "t5_after_err");
    chk("t5_sticky", bus.cmd_err, 1'b1);

    // 6: abort while a fetch is pending
    stall = 1'b1;
    frame_start();
    xfer(8'h03, d);
    xfer(8'h00, d); xfer(8'h00, d); xfer(8'h08, d);
    idle_chk = 1'b0;
    for (int i = 0; i < 3; i++) bit_x(1'b0, r);
    chk("t6_req_pending", bus.rd_req, 1'b1);
    bus.ss = 1'b1;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      clk_wait(1);
      n = i;
      if (!bus.rd_req) break;
    end
    chk("t6_req_drop_in_4", (n <= 4 && !bus.rd_req), 1'b1);
    clk_wait(2);
    chk("t6_miso_idle", bus.miso, 1'b1);
    late_ack = 1'b1;
    clk_wait(3);
    stall = 1'b0;
    idle_chk = 1'b1;
    chk("t6_late_ack_ignored", bus.rd_req, 1'b0);
    send_read(8'h03, 32'h8, 4, "t6_byte");
    chk("t6_lit0", rx[0], 8'h55);

    // reset in the middle of a data phase
    frame_start();
    xfer(8'h03, d);
    xfer(8'h00, d); xfer(8'h00, d); xfer(8'h04, d);
    idle_chk = 1'b0;
    xfer(8'h00, d);
    bit_x(1'b0, r);
    bit_x(1'b0, r);
    err_chk = 1'b0;
    rst_n = 1'b0;
    model_err = 1'b0;
    #1;
    chk("rst2_miso", bus.miso, 1'b1);
    chk("rst2_rd_req", bus.rd_req, 1'b0);
    chk("rst2_rd_addr", bus.rd_addr, 32'h0);
    chk("rst2_cmd_err", bus.cmd_err, 1'b0);
    bus.ss = 1'b1;
    clk_wait(4);
    rst_n = 1'b1;
    clk_wait(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
